// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: opcodes, FSM states,
// access sizes and the opcode decoder used by both the responder and the lane unit.
package dmem_responder_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    acc_size_t size;
    logic      sign_ext;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t info;
    info.is_load  = 1'b0;
    info.is_store = 1'b0;
    info.size     = SZ_WORD;
    info.sign_ext = 1'b0;
    case (op)
      OP_LB:   begin info.is_load = 1'b1; info.size = SZ_BYTE; info.sign_ext = 1'b1; end
      OP_LH:   begin info.is_load = 1'b1; info.size = SZ_HALF; info.sign_ext = 1'b1; end
      OP_LW:   begin info.is_load = 1'b1; info.size = SZ_WORD; end
      OP_LBU:  begin info.is_load = 1'b1; info.size = SZ_BYTE; end
      OP_LHU:  begin info.is_load = 1'b1; info.size = SZ_HALF; end
      OP_SB:   begin info.is_store = 1'b1; info.size = SZ_BYTE; end
      OP_SH:   begin info.is_store = 1'b1; info.size = SZ_HALF; end
      OP_SW:   begin info.is_store = 1'b1; info.size = SZ_WORD; end
      default: info.is_load = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic misaligned(input acc_size_t size, input logic [1:0] byte_off);
    return ((size == SZ_HALF) && byte_off[0]) || ((size == SZ_WORD) && (byte_off != 2'd0));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane handling: extracts and extends load data, merges store data into
// the addressed lanes of the current storage word.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  acc_size_t   acc_size,
  input  logic        sign_ext,
  input  logic [1:0]  byte_off,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, extension and store merge
  always_comb begin
    byte_s = 8'h00;
    case (byte_off)
      2'd0:    byte_s = mem_word[31:24];
      2'd1:    byte_s = mem_word[23:16];
      2'd2:    byte_s = mem_word[15:8];
      2'd3:    byte_s = mem_word[7:0];
      default: byte_s = 8'h00;
    endcase
    if (byte_off[1]) begin
      half_s = mem_word[15:0];
    end else begin
      half_s = mem_word[31:16];
    end

    load_data   = 32'h0000_0000;
    merged_word = mem_word;
    case (acc_size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
        case (byte_off)
          2'd0:    merged_word[31:24] = store_data[7:0];
          2'd1:    merged_word[23:16] = store_data[7:0];
          2'd2:    merged_word[15:8]  = store_data[7:0];
          2'd3:    merged_word[7:0]   = store_data[7:0];
          default: merged_word = mem_word;
        endcase
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_s[15]}}, half_s};
        if (byte_off[1]) begin
          merged_word[15:0] = store_data[15:0];
        end else begin
          merged_word[31:16] = store_data[15:0];
        end
      end
      SZ_WORD: begin
        load_data   = mem_word;
        merged_word = store_data;
      end
      default: begin
        load_data   = 32'h0000_0000;
        merged_word = mem_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: stalls the pipeline for
// LATENCY cycles per access, then pulses Mem_Ready with registered load data/error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [5:0]  Opcode,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_data,
  output logic        MEM_STALL,
  output logic        Mem_Ready,
  output logic        Addr_Err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) + 1 : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            rd_r;
  logic            wr_r;
  logic [5:0]      op_r;
  logic [AW+1:0]   addr_r;
  logic [31:0]     wdata_r;
  logic [31:0]     mem_r [DEPTH_WORDS];

  logic            cur_rd_s;
  logic            cur_wr_s;
  logic [5:0]      cur_op_s;
  logic [AW+1:0]   cur_addr_s;
  logic [31:0]     cur_wdata_s;
  op_info_t        info_s;
  logic            err_s;
  logic            finish_s;
  logic [AW-1:0]   idx_s;
  logic [31:0]     load_data_s;
  logic [31:0]     merged_s;
  logic            addr_unused_s;

  // Address bits above the storage range wrap and are deliberately dropped
  assign addr_unused_s = ^Address[31:AW+2];

  // The access being worked on: live inputs in IDLE, latched copy afterwards
  always_comb begin
    if (state_r == S_IDLE) begin
      cur_rd_s    = MemRead;
      cur_wr_s    = MemWrite;
      cur_op_s    = Opcode;
      cur_addr_s  = Address[AW+1:0];
      cur_wdata_s = Write_Data;
    end else begin
      cur_rd_s    = rd_r;
      cur_wr_s    = wr_r;
      cur_op_s    = op_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end
  end

  assign info_s = decode_op(cur_op_s);
  assign idx_s  = cur_addr_s[AW+1:2];
  assign err_s  = (cur_rd_s & cur_wr_s)
                | (cur_rd_s & ~info_s.is_load)
                | (cur_wr_s & ~info_s.is_store)
                | misaligned(info_s.size, cur_addr_s[1:0]);

  // The edge that enters DONE: commit the store and register the response
  assign finish_s = ((state_r == S_IDLE) && (MemRead | MemWrite) && (LATENCY == 1))
                  | ((state_r == S_BUSY) && (cnt_r == CNT_ONE));

  dmem_lane_align u_lane (
    .acc_size    (info_s.size),
    .sign_ext    (info_s.sign_ext),
    .byte_off    (cur_addr_s[1:0]),
    .mem_word    (mem_r[idx_s]),
    .store_data  (cur_wdata_s),
    .load_data   (load_data_s),
    .merged_word (merged_s)
  );

  // Stall is held off during reset and in DONE so MEM/WB captures on the resume edge
  always_comb begin
    if (RESET) begin
      MEM_STALL = 1'b0;
    end else if (state_r == S_BUSY) begin
      MEM_STALL = 1'b1;
    end else if (state_r == S_IDLE) begin
      MEM_STALL = MemRead | MemWrite;
    end else begin
      MEM_STALL = 1'b0;
    end
  end

  // Access FSM, storage and registered response
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      op_r      <= 6'b000000;
      addr_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      Read_data <= 32'h0000_0000;
      Mem_Ready <= 1'b0;
      Addr_Err  <= 1'b0;
      mem_r     <= '{default: 32'h0000_0000};
    end else begin
      if (finish_s) begin
        Mem_Ready <= 1'b1;
        Addr_Err  <= err_s;
        Read_data <= (cur_rd_s && !err_s) ? load_data_s : 32'h0000_0000;
        if (cur_wr_s && !err_s) begin
          mem_r[idx_s] <= merged_s;
        end
      end else begin
        Mem_Ready <= 1'b0;
        Addr_Err  <= 1'b0;
        Read_data <= 32'h0000_0000;
      end

      case (state_r)
        S_IDLE: begin
          if (MemRead | MemWrite) begin
            rd_r    <= MemRead;
            wr_r    <= MemWrite;
            op_r    <= Opcode;
            addr_r  <= Address[AW+1:0];
            wdata_r <= Write_Data;
            if (LATENCY == 1) begin
              state_r <= S_DONE;
            end else begin
              state_r <= S_BUSY;
              cnt_r   <= CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (cnt_r == CNT_ONE) begin
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 1, 4) driven by
// directed accesses; a monitor checks each Mem_Ready pulse against queued expectations.
module tb_dmem_responder;

  localparam int N       = 3;
  localparam int TIMEOUT = 20;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mr [N];
  logic        mw [N];
  logic [5:0]  op [N];
  logic [31:0] addr [N];
  logic [31:0] wd [N];
  logic [31:0] rdata [N];
  logic        stall [N];
  logic        rdy [N];
  logic        aerr [N];

  exp_t exp_q [N][$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   dummy;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY((g == 1) ? 1 : ((g == 2) ? 4 : 2))
    ) u_dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .MemRead    (mr[g]),
      .MemWrite   (mw[g]),
      .Opcode     (op[g]),
      .Address    (addr[g]),
      .Write_Data (wd[g]),
      .Read_data  (rdata[g]),
      .MEM_STALL  (stall[g]),
      .Mem_Ready  (rdy[g]),
      .Addr_Err   (aerr[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 1) ? 1 : ((k == 2) ? 4 : 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: every Mem_Ready pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (rdy[k] === 1'b1) begin
        n_vec++;
        if (exp_q[k].size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ready dut%0d: got Mem_Ready=1, required no pending access", k);
        end else begin
          e = exp_q[k].pop_front();
          if (rdata[k] !== e.data || aerr[k] !== e.err) begin
            n_bad++;
            $display("FAIL response dut%0d: got data=%h err=%b, required data=%h err=%b",
                     k, rdata[k], aerr[k], e.data, e.err);
          end
        end
      end
    end
  end

  // Issue one access, check stall/ready timing, release the request in DONE
  task automatic req(input int k, input logic r, input logic w, input logic [5:0] o,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee, output int rdy_cyc);
    exp_t e;
    int   n;
    int   st;
    @(negedge CLK);
    mr[k] = r; mw[k] = w; op[k] = o; addr[k] = a; wd[k] = d;
    e.data = ed; e.err = ee;
    exp_q[k].push_back(e);
    n = 0; st = 0;
    #1;
    while (rdy[k] !== 1'b1 && n < TIMEOUT) begin
      if (stall[k] === 1'b1) st++;
      @(negedge CLK);
      addr[k] = ~a; wd[k] = ~d; op[k] = ~o;
      #1;
      n++;
    end
    chk("ready_latency", 32'(n), 32'(lat_of(k)));
    chk("stall_cycles", 32'(st), 32'(lat_of(k)));
    chk("stall_in_done", {31'd0, stall[k]}, 32'd0);
    mr[k] = 1'b0; mw[k] = 1'b0;
    rdy_cyc = cyc;
  endtask

  task automatic b2b(input int k, input logic [31:0] a, input logic [31:0] ed);
    int c0, c1, c2;
    req(k, 1'b1, 1'b0, LW, a, 32'd0, ed, 1'b0, c0);
    req(k, 1'b1, 1'b0, LW, a, 32'd0, ed, 1'b0, c1);
    req(k, 1'b1, 1'b0, LW, a, 32'd0, ed, 1'b0, c2);
    chk("spacing_1", 32'(c1 - c0), 32'(lat_of(k) + 1));
    chk("spacing_2", 32'(c2 - c1), 32'(lat_of(k) + 1));
  endtask

  initial begin
    RESET = 1'b1;
    for (int k = 0; k < N; k++) begin
      mr[k] = 1'b0; mw[k] = 1'b0; op[k] = 6'd0; addr[k] = 32'd0; wd[k] = 32'd0;
    end
    repeat (2) @(negedge CLK);
    for (int k = 0; k < N; k++) begin
      chk("reset_rdata", rdata[k], 32'd0);
      chk("reset_flags", {29'd0, stall[k], rdy[k], aerr[k]}, 32'd0);
    end
    RESET = 1'b0;

    // Word store/load and big-endian lanes
    req(0, 1'b0, 1'b1, SW,  32'd4,  32'd40,        32'd0,        1'b0, dummy);
    req(0, 1'b1, 1'b0, LW,  32'd4,  32'd0,         32'd40,       1'b0, dummy);
    req(0, 1'b0, 1'b1, SW,  32'd8,  32'h11223344,  32'd0,        1'b0, dummy);
    req(0, 1'b1, 1'b0, LB,  32'd9,  32'd0,         32'h00000022, 1'b0, dummy);
    req(0, 1'b1, 1'b0, LBU, 32'd11, 32'd0,         32'h00000044, 1'b0, dummy);
    req(0, 1'b1, 1'b0, LH,  32'd10, 32'd0,         32'h00003344, 1'b0, dummy);
    req(0, 1'b0, 1'b1, SB,  32'd8,  32'h00000080,  32'd0,        1'b0, dummy);
    req(0, 1'b1, 1'b0, LW,  32'd8,  32'd0,         32'h80223344, 1'b0, dummy);
    req(0, 1'b1, 1'b0, LB,  32'd8,  32'd0,         32'hFFFFFF80, 1'b0, dummy);
    req(0, 1'b1, 1'b0, LH,  32'd8,  32'd0,         32'hFFFF8022, 1'b0, dummy);
    req(0, 1'b1, 1'b0, LHU, 32'd8,  32'd0,         32'h00008022, 1'b0, dummy);
    req(0, 1'b0, 1'b1, SH,  32'd10, 32'h1234BEEF,  32'd0,        1'b0, dummy);
    req(0, 1'b1, 1'b0, LW,  32'd8,  32'd0,         32'h8022BEEF, 1'b0, dummy);

    // Rejected accesses leave storage untouched
    req(0, 1'b1, 1'b0, LW,  32'd6,  32'd0,         32'd0,        1'b1, dummy);
    req(0, 1'b0, 1'b1, SH,  32'd3,  32'h0000FFFF,  32'd0,        1'b1, dummy);
    req(0, 1'b1, 1'b0, LW,  32'd0,  32'd0,         32'd0,        1'b0, dummy);
    req(0, 1'b1, 1'b1, LW,  32'd4,  32'hDEADDEAD,  32'd0,        1'b1, dummy);
    req(0, 1'b1, 1'b0, SW,  32'd4,  32'd0,         32'd0,        1'b1, dummy);
    req(0, 1'b0, 1'b1, LW,  32'd4,  32'd1,         32'd0,        1'b1, dummy);
    req(0, 1'b1, 1'b0, 6'b000000, 32'd4, 32'd0,    32'd0,        1'b1, dummy);
    req(0, 1'b1, 1'b0, LW,  32'd4,  32'd0,         32'd40,       1'b0, dummy);

    // Address wrap modulo 1 KiB
    req(0, 1'b0, 1'b1, SW,  32'd1024, 32'd7,       32'd0,        1'b0, dummy);
    req(0, 1'b1, 1'b0, LW,  32'd0,  32'd0,         32'd7,        1'b0, dummy);

    // Back-to-back spacing for each latency build
    b2b(0, 32'd8, 32'h8022BEEF);
    req(1, 1'b0, 1'b1, SW,  32'd16, 32'h5A5A0001,  32'd0,        1'b0, dummy);
    b2b(1, 32'd16, 32'h5A5A0001);
    req(2, 1'b0, 1'b1, SW,  32'd20, 32'h12345678,  32'd0,        1'b0, dummy);
    b2b(2, 32'd20, 32'h12345678);

    // Reset during BUSY aborts the store and never reports it
    @(negedge CLK);
    mw[0] = 1'b1; op[0] = SW; addr[0] = 32'd12; wd[0] = 32'd99;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("abort_rdata", rdata[0], 32'd0);
    chk("abort_flags", {29'd0, stall[0], rdy[0], aerr[0]}, 32'd0);
    mw[0] = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    req(0, 1'b1, 1'b0, LW,  32'd12, 32'd0,         32'd0,        1'b0, dummy);
    req(0, 1'b1, 1'b0, LW,  32'd4,  32'd0,         32'd0,        1'b0, dummy);

    repeat (3) @(negedge CLK);
    for (int k = 0; k < N; k++) begin
      chk("queue_drained", 32'(exp_q[k].size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
